// File: rtl/hvac_pkg.sv
// Shared types and widths for the HVAC sequencer.
// The optional fan output is enabled by defining FAN_OVERRUN_EN.
package hvac_pkg;

  localparam int TEMP_W = 5;
  localparam int THR_W  = TEMP_W + 1;
  localparam logic [THR_W-1:0] TEMP_MAX = THR_W'((1 << TEMP_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    REST = 2'd3
  } hvac_state_e;

endpackage

// File: rtl/hvac_dwell_timer.sv
// Saturating dwell counter with synchronous clear and a ">= limit" flag.
module hvac_dwell_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_at_least
);

  logic [W-1:0] r_cnt;

  // Counter holds at all-ones so a long phase never wraps back below the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_at_least = (r_cnt >= i_limit);

endmodule

// File: rtl/hvac_sequencer.sv
// Thermostat sequencer: hysteresis thresholds, minimum-on and fixed rest phases.
// Defining FAN_OVERRUN_EN adds a fan output held through active and rest phases.
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int HYST           = 2,
  parameter int MIN_ON_CYCLES  = 16,
  parameter int MIN_OFF_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [TEMP_W-1:0] temperature,
  input  logic [TEMP_W-1:0] setpoint,
  output logic              heating,
  output logic              cooling,
`ifdef FAN_OVERRUN_EN
  output logic              fan,
`endif
  output logic [1:0]        state
);

  localparam int CNT_MAX = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ? MIN_ON_CYCLES : MIN_OFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF_CYCLES - 1);

  hvac_state_e      r_state;
  hvac_state_e      w_next_state;
  logic             r_heating;
  logic             r_cooling;
  logic [THR_W-1:0] w_temp;
  logic [THR_W-1:0] w_sp;
  logic [THR_W-1:0] w_hyst;
  logic [THR_W-1:0] w_lo;
  logic [THR_W-1:0] w_hi_raw;
  logic [THR_W-1:0] w_hi;
  logic [CNT_W-1:0] w_limit;
  logic             w_clear;
  logic             w_dwell_done;

  // Thresholds are computed one bit wider so the clamps see true under/overflow.
  assign w_temp   = {1'b0, temperature};
  assign w_sp     = {1'b0, setpoint};
  assign w_hyst   = THR_W'(HYST);
  assign w_lo     = (w_sp >= w_hyst) ? (w_sp - w_hyst) : {THR_W{1'b0}};
  assign w_hi_raw = w_sp + w_hyst;
  assign w_hi     = (w_hi_raw > TEMP_MAX) ? TEMP_MAX : w_hi_raw;

  assign w_limit = (r_state == REST) ? OFF_LIM : ON_LIM;
  assign w_clear = (w_next_state != r_state);

  hvac_dwell_timer #(
    .W (CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_en       (1'b1),
    .i_limit    (w_limit),
    .o_at_least (w_dwell_done)
  );

  // Next-state decision; HEAT and COOL only ever leave through REST.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (enable && (w_temp < w_lo)) begin
          w_next_state = HEAT;
        end else if (enable && (w_temp > w_hi)) begin
          w_next_state = COOL;
        end else begin
          w_next_state = IDLE;
        end
      end
      HEAT: begin
        if (!enable) begin
          w_next_state = REST;
        end else if (w_dwell_done && (w_temp >= w_sp)) begin
          w_next_state = REST;
        end else begin
          w_next_state = HEAT;
        end
      end
      COOL: begin
        if (!enable) begin
          w_next_state = REST;
        end else if (w_dwell_done && (w_temp <= w_sp)) begin
          w_next_state = REST;
        end else begin
          w_next_state = COOL;
        end
      end
      REST: begin
        if (w_dwell_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = REST;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and drive registers update together so outputs track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_heating <= 1'b0;
      r_cooling <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_heating <= (w_next_state == HEAT);
      r_cooling <= (w_next_state == COOL);
    end
  end

`ifdef FAN_OVERRUN_EN
  logic r_fan;

  // REST is only reachable from an active phase, so any non-IDLE state runs the fan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fan <= 1'b0;
    end else begin
      r_fan <= (w_next_state != IDLE);
    end
  end

  assign fan = r_fan;
`endif

  assign heating = r_heating;
  assign cooling = r_cooling;
  assign state   = r_state;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Randomized and directed bench for hvac_sequencer against a phase/age reference model.
module tb_hvac_sequencer;

  localparam int HYST    = 2;
  localparam int MIN_ON  = 16;
  localparam int MIN_OFF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] temperature = 5'd0;
  logic [4:0] setpoint = 5'd20;
  logic       heating;
  logic       cooling;
  logic [1:0] state;
`ifdef FAN_OVERRUN_EN
  logic       fan;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase 0 idle, 1 heat, 2 cool, 3 rest; age = cycles spent in phase
  int m_phase = 0;
  int m_age   = 0;

  hvac_sequencer #(
    .HYST           (HYST),
    .MIN_ON_CYCLES  (MIN_ON),
    .MIN_OFF_CYCLES (MIN_OFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .temperature (temperature),
    .setpoint    (setpoint),
    .heating     (heating),
    .cooling     (cooling),
`ifdef FAN_OVERRUN_EN
    .fan         (fan),
`endif
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the specification's rules, using the inputs the DUT just sampled.
  task automatic model_step();
    int t, sp, lo, hi, nxt;
    t   = int'(temperature);
    sp  = int'(setpoint);
    lo  = (sp - HYST < 0) ? 0 : sp - HYST;
    hi  = (sp + HYST > 31) ? 31 : sp + HYST;
    nxt = m_phase;
    if (rst) begin
      m_phase = 0;
      m_age   = 0;
      return;
    end
    if (m_phase == 0) begin
      if (enable && t < lo) nxt = 1;
      else if (enable && t > hi) nxt = 2;
    end else if (m_phase == 1 || m_phase == 2) begin
      if (!enable) nxt = 3;
      else if (m_age + 1 >= MIN_ON && ((m_phase == 1) ? (t >= sp) : (t <= sp))) nxt = 3;
    end else begin
      if (m_age + 1 == MIN_OFF) nxt = 0;
    end
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state", int'(state), m_phase);
    check_eq("heating", int'(heating), (m_phase == 1) ? 1 : 0);
    check_eq("cooling", int'(cooling), (m_phase == 2) ? 1 : 0);
    check_eq("exclusive", int'(heating & cooling), 0);
`ifdef FAN_OVERRUN_EN
    check_eq("fan", int'(fan), (m_phase != 0) ? 1 : 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int heat_len, rest_len, fan_len, seen_bad;

    // 1. reset with a heat-demanding input pattern
    enable = 1'b1; temperature = 5'd0; setpoint = 5'd20;
    do_reset();
    check_eq("reset_state", int'(state), 0);
    check_eq("reset_heating", int'(heating), 0);
    tick();
    check_eq("first_heat", int'(state), 1);

    // 2. minimum-on and exact rest length
    do_reset();
    temperature = 5'd17;
    tick();
    check_eq("heat_entry", int'(heating), 1);
    heat_len = 1; rest_len = 0; fan_len = 0;
`ifdef FAN_OVERRUN_EN
    fan_len = int'(fan);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      heat_len += int'(heating);
`ifdef FAN_OVERRUN_EN
      fan_len += int'(fan);
`endif
    end
    temperature = 5'd21;
    for (int i = 0; i < 40; i++) begin
      tick();
      heat_len += int'(heating);
      rest_len += (state == 2'd3) ? 1 : 0;
`ifdef FAN_OVERRUN_EN
      fan_len += int'(fan);
`endif
    end
    check_eq("heat_len", heat_len, MIN_ON);
    check_eq("rest_len", rest_len, MIN_OFF);
    check_eq("back_idle", int'(state), 0);
`ifdef FAN_OVERRUN_EN
    check_eq("fan_len", fan_len, MIN_ON + MIN_OFF);
`endif

    // 3. hysteresis band edges
    do_reset();
    temperature = 5'd18;
    for (int i = 0; i < 4; i++) tick();
    check_eq("lo_edge_idle", int'(state), 0);
    temperature = 5'd22;
    for (int i = 0; i < 4; i++) tick();
    check_eq("hi_edge_idle", int'(state), 0);
    temperature = 5'd23;
    tick();
    check_eq("cool_entry", int'(cooling), 1);

    // 4. direction change through REST
    do_reset();
    temperature = 5'd17;
    tick();
    temperature = 5'd30;
    for (int i = 0; i < 30; i++) tick();
    check_eq("dir_change_cool", int'(state), 2);

    // 5. enable drop and reset mid-rest
    do_reset();
    temperature = 5'd17;
    for (int i = 0; i < 6; i++) tick();
    enable = 1'b0;
    tick();
    check_eq("disable_rest", int'(state), 3);
    check_eq("disable_heat_off", int'(heating), 0);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b1;
    tick();
    check_eq("rst_in_rest", int'(state), 0);
    rst = 1'b0;

    // 6. clamp boundaries
    do_reset();
    setpoint = 5'd1; temperature = 5'd0;
    seen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_bad += (state == 2'd1) ? 1 : 0;
    end
    check_eq("clamp_no_heat", seen_bad, 0);
    setpoint = 5'd30; temperature = 5'd31;
    seen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_bad += (state == 2'd2) ? 1 : 0;
    end
    check_eq("clamp_no_cool", seen_bad, 0);

    // randomized soak: slowly wandering temperature, occasional setpoint, enable, reset changes
    setpoint = 5'd16; temperature = 5'd16;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) temperature = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 60) == 0) setpoint = 5'($urandom_range(0, 31));
      enable = ($urandom_range(0, 30) != 0);
      rst    = ($urandom_range(0, 300) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
